// File: rtl/cf_spi_pkg.sv
// Shared types and constants for the CF_SPI bit engine (cf_spi_shifter, cf_spi_clkgen).
package cf_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Edge counter must hold the value 2*dw.
  function automatic int ecnt_width(input int dw);
    return $clog2(2 * dw) + 1;
  endfunction

endpackage

// File: rtl/cf_spi_clkgen.sv
// sclk divider for cf_spi_shifter: one tick per clk_divider+1 cycles, plus a
// leading/trailing flag for the sclk edge that the tick produces.
module cf_spi_clkgen
  import cf_spi_pkg::*;
#(
  parameter int CDW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           restart,
  input  logic           run,
  input  logic [CDW-1:0] div,
  output logic           tick,
  output logic           leading
);

  logic [CDW-1:0] cnt;
  logic           armed;
  logic           phase;

  // One settling cycle after restart gives mosi a full clk of setup before the
  // divider starts counting toward the first sclk edge.
  assign tick    = run && armed && (cnt == div);
  assign leading = ~phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      armed <= 1'b0;
      phase <= 1'b0;
    end else if (run) begin
      if (!armed) begin
        armed <= 1'b1;
      end else if (tick) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cf_spi_shifter.sv
// SPI master bit engine: all four CPOL/CPHA modes, programmable sclk divider.
// Optional CF_SPI_LSB_FIRST_EN adds an lsb_first input for LSB-first transfers.
//
// state   | meaning
// IDLE    | waiting for go with enable high
// XFER    | generating 2*DW sclk edges, shifting mosi / sampling miso
// TAIL    | chip-select hold of clk_divider+1 cycles, then done pulse
module cf_spi_shifter
  import cf_spi_pkg::*;
#(
  parameter int DW  = 8,
  parameter int CDW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cpol,
  input  logic           cpha,
  input  logic [CDW-1:0] clk_divider,
  input  logic           enable,
  input  logic           go,
  input  logic [DW-1:0]  datai,
  output logic [DW-1:0]  datao,
  output logic           busy,
  output logic           done,
  input  logic           miso,
  output logic           mosi,
  output logic           sclk
`ifdef CF_SPI_LSB_FIRST_EN
  ,
  input  logic           lsb_first
`endif
);

  localparam int             ECW       = ecnt_width(DW);
  localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DW - 1);

  state_t         state_q, state_d;
  logic           cpol_l, cpha_l, lsb_l, lsb_go;
  logic [CDW-1:0] div_l;
  logic [DW-1:0]  sr;
  logic [ECW-1:0] ecnt;
  logic           accept, abort, finish;
  logic           tick, leading, edge_x, last_edge, sample_edge;

`ifdef CF_SPI_LSB_FIRST_EN
  assign lsb_go = lsb_first;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lsb_l <= 1'b0;
    else if (accept) lsb_l <= lsb_first;
  end
`else
  assign lsb_go = 1'b0;
  assign lsb_l  = 1'b0;
`endif

  function automatic logic tx_bit(input logic [DW-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DW-1];
  endfunction

  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] v, input logic b,
                                             input logic lsb);
    return lsb ? {b, v[DW-1:1]} : {v[DW-2:0], b};
  endfunction

  cf_spi_clkgen #(.CDW(CDW)) u_clkgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .run     (state_q != ST_IDLE),
    .div     (div_l),
    .tick    (tick),
    .leading (leading)
  );

  assign edge_x      = (state_q == ST_XFER) && enable && tick;
  assign last_edge   = (ecnt == LAST_EDGE);
  assign sample_edge = leading ^ cpha_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    abort   = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go && enable) begin
          accept  = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!enable) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (tick && last_edge) begin
          state_d = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (!enable) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (tick) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      div_l  <= '0;
      sr     <= '0;
      ecnt   <= '0;
      datao  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mosi   <= 1'b0;
      sclk   <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        cpol_l <= cpol;
        cpha_l <= cpha;
        div_l  <= clk_divider;
        sr     <= datai;
        ecnt   <= '0;
        busy   <= 1'b1;
        sclk   <= cpol;
        mosi   <= tx_bit(datai, lsb_go);
      end else if (abort) begin
        busy <= 1'b0;
        sclk <= cpol_l;
      end else if (finish) begin
        busy  <= 1'b0;
        datao <= sr;
      end else if (edge_x) begin
        sclk <= ~sclk;
        ecnt <= ecnt + 1'b1;
        // The final edge is always trailing; no further bit goes out after it.
        if (sample_edge)     sr   <= shift_in(sr, miso, lsb_l);
        else if (!last_edge) mosi <= tx_bit(sr, lsb_l);
      end
    end
  end

endmodule

// File: tb/tb_cf_spi_shifter.sv
// Directed bench for cf_spi_shifter: modes 0..3, divider, back-to-back, abort, reset.
module tb_cf_spi_shifter;
  import cf_spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, enable = 1'b0, go = 1'b0;
  logic [7:0] clk_divider = '0, datai = '0;
  logic [7:0] datao;
  logic       busy, done, mosi, sclk, miso;
`ifdef CF_SPI_LSB_FIRST_EN
  logic       lsb_first = 1'b0;
`endif

  int n_tests = 0, n_fail = 0;
  int cyc = 0, t0 = 0;
  int miso_sel = 0;
  logic [7:0] slave_pat = '0;
  logic slave_bit = 1'b0;
  int slave_idx = 0;
  logic cur_cpol = 1'b0, cur_cpha = 1'b0;
  logic prev_busy = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int n_done, done_rel, n_edge, n_lead, n_rise, last_rise_rel;
  int lead_chg, trail_chg, other_chg, first_edge_rel, second_edge_rel;
  int busy_first, busy_last;
  logic [15:0] tx_cap;

  assign miso = (miso_sel == 0) ? mosi : (miso_sel == 1) ? 1'b1 : slave_bit;

  cf_spi_shifter #(.DW(8), .CDW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpol        (cpol),
    .cpha        (cpha),
    .clk_divider (clk_divider),
    .enable      (enable),
    .go          (go),
    .datai       (datai),
    .datao       (datao),
    .busy        (busy),
    .done        (done),
    .miso        (miso),
    .mosi        (mosi),
    .sclk        (sclk)
`ifdef CF_SPI_LSB_FIRST_EN
    ,
    .lsb_first   (lsb_first)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_done = 0; done_rel = -1; n_edge = 0; n_lead = 0; n_rise = 0; last_rise_rel = -1;
    lead_chg = 0; trail_chg = 0; other_chg = 0; first_edge_rel = -1; second_edge_rel = -1;
    busy_first = -1; busy_last = -1; tx_cap = '0; slave_idx = 0;
  endtask

  // Passive monitor sampling at the falling edge of clk.
  always @(negedge clk) begin : mon
    int rel;
    logic is_edge, is_lead;
    rel     = cyc - t0;
    is_edge = busy && prev_busy && (sclk !== prev_sclk);
    is_lead = is_edge && (prev_sclk == cur_cpol);
    if (busy && !prev_busy) begin n_rise++; last_rise_rel = rel; end
    if (busy) begin
      if (busy_first < 0) busy_first = rel;
      busy_last = rel;
    end
    if (done) begin
      n_done++;
      if (done_rel < 0) done_rel = rel;
    end
    if (is_edge) begin
      n_edge++;
      if (n_edge == 1) first_edge_rel = rel;
      else if (n_edge == 2) second_edge_rel = rel;
      if (is_lead) n_lead++;
      if (is_lead ^ cur_cpha) tx_cap = {tx_cap[14:0], mosi};
      if (is_lead && slave_idx < 8) begin
        slave_idx++;
        slave_bit = slave_pat[8 - slave_idx];
      end
    end
    if (busy && prev_busy && (mosi !== prev_mosi)) begin
      if (!is_edge)     other_chg++;
      else if (is_lead) lead_chg++;
      else              trail_chg++;
    end
    prev_busy = busy;
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  task automatic start_xfer(input logic [1:0] mode, input logic [7:0] div, input logic [7:0] d,
                            input int msel, input logic [7:0] pat, input logic keep_go);
    @(negedge clk);
    cpol = mode[1]; cpha = mode[0]; clk_divider = div; datai = d;
    miso_sel = msel; slave_pat = pat; cur_cpol = mode[1]; cur_cpha = mode[0];
    enable = 1'b1; go = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    clear_stats();
    go = keep_go;
  endtask

  task automatic wait_n_done(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, n_done >= target, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    #12;
    check("reset_outputs", {busy, done, sclk, mosi, datao}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, divider 0, loopback
    start_xfer(SPI_MODE0, 8'd0, 8'hA5, 0, 8'h00, 1'b0);
    wait_n_done(1, 100, "m0_done_timeout");
    repeat (3) @(negedge clk);
    #1;
    check("m0_done_cycle", done_rel, 18);
    check("m0_busy_first", busy_first, 0);
    check("m0_busy_last", busy_last, 17);
    check("m0_datao", datao, 8'hA5);
    check("m0_rising_edges", n_lead, 8);
    check("m0_mosi_seq", tx_cap[7:0], 8'hA5);
    check("m0_sclk_idle", sclk, 1'b0);
    check("m0_mosi_glitch", other_chg, 0);
    check("m0_done_count", n_done, 1);

    // Mode 3, divider 3, slave shifting C3
    start_xfer(SPI_MODE3, 8'd3, 8'h3C, 2, 8'hC3, 1'b0);
    wait_n_done(1, 200, "m3_done_timeout");
    repeat (2) @(negedge clk);
    #1;
    check("m3_done_cycle", done_rel, 69);
    check("m3_first_edge", first_edge_rel, 5);
    check("m3_half_period", second_edge_rel - first_edge_rel, 4);
    check("m3_datao", datao, 8'hC3);
    check("m3_mosi_seq", tx_cap[7:0], 8'h3C);
    check("m3_sclk_idle", sclk, 1'b1);

    // Mode 1: mosi moves on leading edges only
    start_xfer(SPI_MODE1, 8'd1, 8'h81, 1, 8'h00, 1'b0);
    wait_n_done(1, 100, "m1_done_timeout");
    repeat (2) @(negedge clk);
    #1;
    check("m1_datao", datao, 8'hFF);
    check("m1_lead_chg", lead_chg, 2);
    check("m1_trail_chg", trail_chg + other_chg, 0);
    check("m1_mosi_seq", tx_cap[7:0], 8'h81);

    // Mode 2: mosi moves on trailing edges only
    start_xfer(SPI_MODE2, 8'd1, 8'h81, 1, 8'h00, 1'b0);
    wait_n_done(1, 100, "m2_done_timeout");
    repeat (2) @(negedge clk);
    #1;
    check("m2_datao", datao, 8'hFF);
    check("m2_trail_chg", trail_chg, 2);
    check("m2_lead_chg", lead_chg + other_chg, 0);
    check("m2_sclk_idle", sclk, 1'b1);

    // Back-to-back with go held high
    start_xfer(SPI_MODE0, 8'd0, 8'h12, 0, 8'h00, 1'b1);
    datai = 8'h34;
    wait_n_done(1, 100, "b2b_first_timeout");
    @(negedge clk);
    #1;
    go = 1'b0;
    wait_n_done(2, 100, "b2b_second_timeout");
    repeat (3) @(negedge clk);
    #1;
    check("b2b_done_count", n_done, 2);
    check("b2b_busy_rises", n_rise, 2);
    check("b2b_second_rise", last_rise_rel, done_rel + 1);
    check("b2b_datao", datao, 8'h34);
    check("b2b_mosi_seq", tx_cap, 16'h1234);

    // Abort after edge 5
    start_xfer(SPI_MODE2, 8'd1, 8'h5A, 0, 8'h00, 1'b0);
    begin
      int k;
      k = 0;
      while (n_edge < 5 && k < 100) begin
        @(negedge clk);
        #1;
        k++;
      end
      check("abort_edge5_reached", n_edge, 5);
    end
    enable = 1'b0;
    @(negedge clk);
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_sclk", sclk, 1'b1);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_datao_kept", datao, 8'h34);

    // Asynchronous reset mid-transfer
    start_xfer(SPI_MODE0, 8'd2, 8'hFF, 0, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    check("rst_mid_busy_before", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {busy, done, sclk, mosi, datao}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // go while disabled is ignored
    @(negedge clk);
    enable = 1'b0;
    go = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("go_disabled_busy", busy, 1'b0);
    go = 1'b0;
    enable = 1'b1;

`ifdef CF_SPI_LSB_FIRST_EN
    lsb_first = 1'b1;
    start_xfer(SPI_MODE0, 8'd0, 8'h01, 0, 8'h00, 1'b0);
    check("lsb_first_mosi", mosi, 1'b1);
    wait_n_done(1, 100, "lsb_done_timeout");
    repeat (2) @(negedge clk);
    #1;
    check("lsb_datao", datao, 8'h01);
    check("lsb_mosi_seq", tx_cap[7:0], 8'h80);
    lsb_first = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
